// File: rtl/writeback_regfile.sv
// Writeback stage: one-entry pending register feeding a 2**ADDR_W x DATA_W regfile; optional WB_BYPASS_EN forwards pending data to the read port.
// Latency: result committed 2 edges after wb_valid (1 edge visible on rd_data with WB_BYPASS_EN); read port is combinational.
// Backpressure: none; accepts one result per cycle, back-to-back commits in order.
module writeback_regfile #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] result,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              zero_flag,
  output logic [15:0]       commit_count
);

  localparam int NREG = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } pend_t;

  logic [DATA_W-1:0] regs [NREG];
  logic              pend_valid;
  pend_t             pend;
  logic              pend_is_r0;
  logic              rd_is_r0;

  assign pend_is_r0 = ZERO_R0 && (pend.addr == '0);
  assign rd_is_r0   = ZERO_R0 && (rd_addr == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend       <= '0;
    end else begin
      pend_valid <= wb_valid;
      if (wb_valid) begin
        pend.addr <= write_addr;
        pend.data <= result;
      end
    end
  end

  // A hard-wired R0 drops the array write but still counts as a commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (pend_valid && !pend_is_r0) begin
      regs[pend.addr] <= pend.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_flag    <= 1'b0;
      commit_count <= '0;
    end else if (pend_valid) begin
      zero_flag <= (pend.data == '0);
      if (commit_count != 16'hFFFF) commit_count <= commit_count + 16'd1;
    end
  end

  always_comb begin
    rd_data = regs[rd_addr];
    if (rd_is_r0) begin
      rd_data = '0;
    end
`ifdef WB_BYPASS_EN
    else if (pend_valid && (rd_addr == pend.addr)) begin
      rd_data = pend.data;
    end
`else
`endif
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: two instances (ZERO_R0=0 and ZERO_R0=1) share stimulus;
// expected values are queued at issue time and compared by a negedge monitor.
module tb_writeback_regfile;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wb_valid = 1'b0;
  logic [3:0] write_addr = '0;
  logic [7:0] result = '0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data0, rd_data1;
  logic       zero_flag0, zero_flag1;
  logic [15:0] commit_count0, commit_count1;

  logic chk_req = 1'b0;
  int   checks = 0;
  int   failures = 0;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [7:0]  rd0;
    logic [7:0]  rd1;
    logic        zf;
    logic [15:0] cnt;
  } exp_t;

  exp_t  expq[$];
  string nameq[$];

  writeback_regfile #(.DATA_W(8), .ADDR_W(4), .ZERO_R0(1'b0)) dut0 (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .write_addr(write_addr),
    .result(result), .rd_addr(rd_addr), .rd_data(rd_data0),
    .zero_flag(zero_flag0), .commit_count(commit_count0)
  );

  writeback_regfile #(.DATA_W(8), .ADDR_W(4), .ZERO_R0(1'b1)) dut1 (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .write_addr(write_addr),
    .result(result), .rd_addr(rd_addr), .rd_data(rd_data1),
    .zero_flag(zero_flag1), .commit_count(commit_count1)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string field, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, field, act, exp_v);
    end
  endtask

  // Monitor: pops one expectation per requested sample.
  always @(negedge clk) begin
    if (chk_req) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL monitor_underflow actual=0 required=1");
      end else begin
        exp_t  e;
        string nm;
        e  = expq.pop_front();
        nm = nameq.pop_front();
        cmp(nm, "rd0",  int'(rd_data0),      int'(e.rd0));
        cmp(nm, "rd1",  int'(rd_data1),      int'(e.rd1));
        cmp(nm, "zf0",  int'(zero_flag0),    int'(e.zf));
        cmp(nm, "zf1",  int'(zero_flag1),    int'(e.zf));
        cmp(nm, "cnt0", int'(commit_count0), int'(e.cnt));
        cmp(nm, "cnt1", int'(commit_count1), int'(e.cnt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One result presented for exactly one rising edge.
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wb_valid   = 1'b1;
    write_addr = a;
    result     = d;
    tick();
    wb_valid   = 1'b0;
  endtask

  // Sample at the next falling edge; never crosses a rising edge.
  task automatic check(input string nm, input logic [3:0] a, input logic [7:0] e0,
                       input logic [7:0] e1, input logic ez, input logic [15:0] ec);
    exp_t e;
    e.rd0 = e0;
    e.rd1 = e1;
    e.zf  = ez;
    e.cnt = ec;
    rd_addr = a;
    expq.push_back(e);
    nameq.push_back(nm);
    chk_req = 1'b1;
    @(negedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  initial begin
    // Reset: every address reads zero in both instances
    repeat (3) tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] a;
      a = 4'(i);
      check("reset_rd", a, 8'h00, 8'h00, 1'b0, 16'd0);
    end

    // Single write: 1-edge visibility only with bypass, committed after 2 edges
    wr(4'd3, 8'h05);
    check("r3_one_edge", 4'd3, BYP ? 8'h05 : 8'h00, BYP ? 8'h05 : 8'h00, 1'b0, 16'd0);
    tick();
    check("r3_two_edge", 4'd3, 8'h05, 8'h05, 1'b0, 16'd1);

    // Back-to-back: R7<=11, R7<=22, R2<=00
    wr(4'd7, 8'h11);
    wr(4'd7, 8'h22);
    check("r7_mid", 4'd7, BYP ? 8'h22 : 8'h11, BYP ? 8'h22 : 8'h11, 1'b0, 16'd2);
    wr(4'd2, 8'h00);
    check("r7_final", 4'd7, 8'h22, 8'h22, 1'b0, 16'd3);
    tick();
    check("r2_zero", 4'd2, 8'h00, 8'h00, 1'b1, 16'd4);

    // Register 0: writable in dut0, hard-wired zero in dut1, counted in both
    wr(4'd0, 8'hFF);
    tick();
    check("r0_ff", 4'd0, 8'hFF, 8'h00, 1'b0, 16'd5);
    wr(4'd0, 8'hAA);
    check("r0_pend", 4'd0, BYP ? 8'hAA : 8'hFF, 8'h00, 1'b0, 16'd5);
    tick();
    check("r0_aa", 4'd0, 8'hAA, 8'h00, 1'b0, 16'd6);

    // Reset between E0 and E1 discards the pending write
    wr(4'd4, 8'h9A);
    rst = 1'b1;
    check("rst_mid", 4'd4, 8'h00, 8'h00, 1'b0, 16'd0);
    tick();
    rst = 1'b0;
    tick();
    check("r4_after_rst", 4'd4, 8'h00, 8'h00, 1'b0, 16'd0);
    check("r7_after_rst", 4'd7, 8'h00, 8'h00, 1'b0, 16'd0);

    // Drive the counter to FFFE, then three more commits must saturate
    for (int i = 0; i < 65534; i++) begin
      wb_valid   = 1'b1;
      write_addr = 4'd1;
      result     = i[7:0];
      tick();
    end
    wb_valid = 1'b0;
    tick();
    check("cnt_fffe", 4'd1, 8'hFD, 8'hFD, 1'b0, 16'hFFFE);
    wr(4'd5, 8'h01);
    wr(4'd5, 8'h02);
    check("cnt_ffff", 4'd5, BYP ? 8'h02 : 8'h01, BYP ? 8'h02 : 8'h01, 1'b0, 16'hFFFF);
    wr(4'd6, 8'h00);
    tick();
    check("cnt_sat", 4'd5, 8'h02, 8'h02, 1'b1, 16'hFFFF);

    repeat (2) tick();
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
